// File: rtl/mod_data_mem_wait_pkg.sv
// Shared constants for the wait-state data memory: FSM encodings and wait-counter limits.
package mod_data_mem_wait_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_DUMP = 2'd3
    } state_e;

    localparam int WAIT_STATES_MAX = 15;
    localparam int WAIT_CNT_W      = 4;

endpackage

// File: rtl/mod_data_mem_wait_mem_array.sv
// Word storage: one synchronous byte-enabled write port, one asynchronous read port.
module mod_mem_array
    import mod_data_mem_wait_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic                    clk,
    input  logic                    we,
    input  logic [IDX_W-1:0]        waddr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic [IDX_W-1:0]        raddr,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem_r [DEPTH_WORDS];

    // Byte-masked write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (byte_en[b]) begin
                    mem_r[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/mod_data_mem_wait.sv
// Data memory with a fixed number of wait states per access, error reporting and a full-memory dump stream.
module mod_data_mem_wait
    import mod_data_mem_wait_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [ADDR_WIDTH-1:0]   data_address_1,
    input  logic [DATA_WIDTH-1:0]   write_data,
    input  logic [DATA_WIDTH/8-1:0] byte_en,
    input  logic                    dump_mem,
    output logic [DATA_WIDTH-1:0]   data_out_1,
    output logic                    ready,
    output logic                    stall,
    output logic                    err,
    output logic                    dump_valid,
    output logic [ADDR_WIDTH-1:0]   dump_addr,
    output logic [DATA_WIDTH-1:0]   dump_data,
    output logic                    dump_done
);

    localparam int BE_W   = DATA_WIDTH / 8;
    localparam int IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int WIDX_W = ADDR_WIDTH - 2;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : {WAIT_CNT_W{1'b0}};
    localparam logic [IDX_W-1:0]  DUMP_LAST = IDX_W'(DEPTH_WORDS - 1);
    localparam logic [WIDX_W-1:0] DEPTH_LIM = WIDX_W'(DEPTH_WORDS);

    state_e                  state_r, state_nxt_s;
    logic [WAIT_CNT_W-1:0]   cnt_r, cnt_nxt_s;
    logic [IDX_W-1:0]        dump_idx_r, dump_idx_nxt_s;
    logic [WIDX_W-1:0]       widx_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [BE_W-1:0]         be_r;
    logic                    write_r, both_r;

    logic                    req_s, accept_s, go_resp_s, in_range_s, mem_we_s;
    logic [WIDX_W-1:0]       cur_widx_s;
    logic [DATA_WIDTH-1:0]   cur_wdata_s, rdata_s;
    logic [BE_W-1:0]         cur_be_s;
    logic                    cur_write_s, cur_both_s;
    logic [IDX_W-1:0]        rd_idx_s;

    logic                    ready_nxt_s, err_nxt_s, dump_valid_nxt_s, dump_done_nxt_s;
    logic [DATA_WIDTH-1:0]   data_out_nxt_s, dump_data_nxt_s;
    logic [ADDR_WIDTH-1:0]   dump_addr_nxt_s;

    assign req_s     = mem_read | mem_write;
    assign accept_s  = (state_r == ST_IDLE) & req_s & ~dump_mem;
    assign go_resp_s = (state_nxt_s == ST_RESP);

    // With zero wait states the access completes on its acceptance edge, so the live inputs are used.
    assign cur_widx_s  = (state_r == ST_IDLE) ? data_address_1[ADDR_WIDTH-1:2] : widx_r;
    assign cur_wdata_s = (state_r == ST_IDLE) ? write_data : wdata_r;
    assign cur_be_s    = (state_r == ST_IDLE) ? byte_en : be_r;
    assign cur_write_s = (state_r == ST_IDLE) ? mem_write : write_r;
    assign cur_both_s  = (state_r == ST_IDLE) ? (mem_read & mem_write) : both_r;
    assign in_range_s  = (cur_widx_s < DEPTH_LIM);
    assign mem_we_s    = go_resp_s & cur_write_s & in_range_s & reset;
    assign rd_idx_s    = (state_r == ST_DUMP) ? dump_idx_r : cur_widx_s[IDX_W-1:0];
    assign stall       = (req_s & ~ready) | (state_r == ST_DUMP);

    mod_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_mem_array (
        .clk    (clk),
        .we     (mem_we_s),
        .waddr  (cur_widx_s[IDX_W-1:0]),
        .wdata  (cur_wdata_s),
        .byte_en(cur_be_s),
        .raddr  (rd_idx_s),
        .rdata  (rdata_s)
    );

    // State register, counters and request latch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {WAIT_CNT_W{1'b0}};
            dump_idx_r <= {IDX_W{1'b0}};
            widx_r     <= {WIDX_W{1'b0}};
            wdata_r    <= {DATA_WIDTH{1'b0}};
            be_r       <= {BE_W{1'b0}};
            write_r    <= 1'b0;
            both_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            cnt_r      <= cnt_nxt_s;
            dump_idx_r <= dump_idx_nxt_s;
            if (accept_s) begin
                widx_r  <= data_address_1[ADDR_WIDTH-1:2];
                wdata_r <= write_data;
                be_r    <= byte_en;
                write_r <= mem_write;
                both_r  <= mem_read & mem_write;
            end
        end
    end

    // Next-state logic; a dump request wins over a simultaneous access in IDLE.
    always_comb begin
        state_nxt_s    = state_r;
        cnt_nxt_s      = cnt_r;
        dump_idx_nxt_s = dump_idx_r;
        case (state_r)
            ST_IDLE: begin
                if (dump_mem) begin
                    state_nxt_s    = ST_DUMP;
                    dump_idx_nxt_s = {IDX_W{1'b0}};
                end else if (req_s) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt_s = ST_RESP;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = WAIT_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == {WAIT_CNT_W{1'b0}}) begin
                    state_nxt_s = ST_RESP;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            ST_DUMP: begin
                if (dump_idx_r == DUMP_LAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    dump_idx_nxt_s = dump_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; read data holds until the next read completes.
    always_comb begin
        ready_nxt_s      = go_resp_s;
        err_nxt_s        = go_resp_s & (cur_both_s | ~in_range_s);
        data_out_nxt_s   = data_out_1;
        dump_valid_nxt_s = (state_r == ST_DUMP);
        dump_done_nxt_s  = (state_r == ST_DUMP) & (dump_idx_r == DUMP_LAST);
        dump_addr_nxt_s  = {ADDR_WIDTH{1'b0}};
        dump_data_nxt_s  = {DATA_WIDTH{1'b0}};
        if (go_resp_s && !cur_write_s) begin
            data_out_nxt_s = in_range_s ? rdata_s : {DATA_WIDTH{1'b0}};
        end else begin
            data_out_nxt_s = data_out_1;
        end
        if (state_r == ST_DUMP) begin
            dump_addr_nxt_s = ADDR_WIDTH'(dump_idx_r) << 2'd2;
            dump_data_nxt_s = rdata_s;
        end else begin
            dump_addr_nxt_s = {ADDR_WIDTH{1'b0}};
            dump_data_nxt_s = {DATA_WIDTH{1'b0}};
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ready      <= 1'b0;
            err        <= 1'b0;
            data_out_1 <= {DATA_WIDTH{1'b0}};
            dump_valid <= 1'b0;
            dump_addr  <= {ADDR_WIDTH{1'b0}};
            dump_data  <= {DATA_WIDTH{1'b0}};
            dump_done  <= 1'b0;
        end else begin
            ready      <= ready_nxt_s;
            err        <= err_nxt_s;
            data_out_1 <= data_out_nxt_s;
            dump_valid <= dump_valid_nxt_s;
            dump_addr  <= dump_addr_nxt_s;
            dump_data  <= dump_data_nxt_s;
            dump_done  <= dump_done_nxt_s;
        end
    end

endmodule

// File: doc/mod_data_mem_wait.md
MOD_DATA_MEM_WAIT -- requirements
Module: mod_data_mem_wait

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, data word width; it SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 32, byte-address width.
REQ-003 The block SHALL have parameter DEPTH_WORDS, default 256, number of words stored.
REQ-004 The block SHALL have parameter WAIT_STATES, default 2, extra cycles per access, range 0..15.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, synchronous active-low reset.
REQ-007 The block SHALL have ports mem_read and mem_write, input, 1 each, access request strobes.
REQ-008 The block SHALL have port data_address_1, input, ADDR_WIDTH, byte address; word index = data_address_1[ADDR_WIDTH-1:2].
REQ-009 The block SHALL have port write_data, input, DATA_WIDTH, store data.
REQ-010 The block SHALL have port byte_en, input, DATA_WIDTH/8, per-byte write enables.
REQ-011 The block SHALL have port dump_mem, input, 1, request a full-memory dump.
REQ-012 The block SHALL have port data_out_1, output, DATA_WIDTH, read data.
REQ-013 The block SHALL have port ready, output, 1, one-cycle access-complete pulse.
REQ-014 The block SHALL have port stall, output, 1, processor hold request.
REQ-015 The block SHALL have port err, output, 1, one-cycle error pulse coincident with ready.
REQ-016 The block SHALL have ports dump_valid (1), dump_addr (ADDR_WIDTH), dump_data (DATA_WIDTH), output, dump stream; dump_done (1), output, completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT, RESP, DUMP.
REQ-018 In IDLE, a request (mem_read|mem_write) SHALL be accepted at the clock edge: address, write_data, byte_en and the access type latched; next state WAIT, or RESP when WAIT_STATES=0.
REQ-019 WAIT SHALL last exactly WAIT_STATES cycles, counted by a 4-bit down-counter, then go to RESP.
REQ-020 ready SHALL be high for exactly the one RESP cycle; RESP SHALL always go to IDLE; total latency = WAIT_STATES+1 cycles from acceptance edge to ready.
REQ-021 A write SHALL commit on the edge entering RESP, updating only bytes whose byte_en bit is 1.
REQ-022 data_out_1 SHALL be registered on the edge entering RESP and held until the next read completes; writes SHALL NOT change it.
REQ-023 stall SHALL be combinational: (mem_read|mem_write) & ~ready, also 1 during DUMP.
REQ-024 A request still asserted in IDLE after RESP SHALL be accepted as a new access.
REQ-025 mem_read and mem_write both high SHALL be executed as a write, with err=1 in RESP.
REQ-026 Word index >= DEPTH_WORDS SHALL suppress the write, return data_out_1=0 for a read, and set err=1 in RESP.
REQ-027 data_address_1[1:0] != 0 SHALL be ignored for addressing (word-aligned).
REQ-028 dump_mem high in IDLE SHALL take priority over a simultaneous request and enter DUMP; dump_mem outside IDLE SHALL be ignored.
REQ-029 In DUMP, one word per cycle SHALL be emitted with dump_valid=1, dump_addr=4*index, index 0..DEPTH_WORDS-1; dump_done SHALL pulse with the last word; next state IDLE.

Reset
REQ-030 With reset=0 at a rising edge: state IDLE, counters 0, and ready, err, data_out_1, dump_valid, dump_addr, dump_data, dump_done all 0.
REQ-031 Reset mid-access or mid-dump SHALL abort it; a pending write SHALL NOT commit.
REQ-032 Memory contents SHALL NOT be cleared by reset.

Structure
REQ-033 The FSM state encodings and the WAIT_STATES upper bound SHALL be constants in the shared core defines file.
REQ-034 Storage SHALL be a sub-module mod_mem_array (one sync write port with byte enables, one async read port); the FSM SHALL be in mod_data_mem_wait.

Verification
REQ-035 WAIT_STATES=2: write 0xDEADBEEF to 0x10, byte_en=4'hF -> ready on the 3rd cycle after acceptance; stall high for 2 cycles.
REQ-036 Read 0x10 after REQ-035 -> data_out_1=0xDEADBEEF with ready, err=0.
REQ-037 Write 0x000000AA to 0x10, byte_en=4'b0001, then read -> 0xDEADBEAA.
REQ-038 DEPTH_WORDS=256: read 0x400 -> data_out_1=0, err=1; a write there leaves word 0 unchanged.
REQ-039 WAIT_STATES=0: back-to-back reads with mem_read held -> ready every 2nd cycle.
REQ-040 dump_mem with a simultaneous read in IDLE -> 256 dump_valid cycles, dump_addr 0..0x3FC, dump_done on the last; the read is then served; reset mid-dump -> dump_valid=0 next cycle.
